tmds_link_ctrl: RTL and testbench
=================================

// Module: tmds_link_ctrl
// PURPOSE
//  Start-up and lock-loss sequencer for the three serializer_10to1 TMDS lanes. Runs in the
//  pixel clock domain and qualifies PLL lock. Holds the serializers in reset, then drives
//  control tokens until the link is trained. After that it passes the encoded pixel data
//  through, and it restarts the sequence on any loss of lock.
// PARAMETERS
//  LOCK_STABLE    1024           cycles synced lock must stay high before release (1..65535)
//  SER_RST_CYCLES 16             cycles o_ser_rst held after lock qualified (1..65535)
//  IDLE_CYCLES    64             cycles of CTRL_TOKEN sent before data pass-through (1..65535)
//  CTRL_TOKEN     10'b1101010100 TMDS control token (C1=0,C0=0) driven when not ACTIVE
// PORTS
//  i_clk          in   1   pixel clock (serializer low-speed clock)
//  i_rst_n        in   1   reset, synchronous, active-low
//  i_clk_lock     in   1   PLL lock, asynchronous to i_clk
//  i_tmds_ch0     in   10  encoded TMDS symbol, lane 0
//  i_tmds_ch1     in   10  encoded TMDS symbol, lane 1
//  i_tmds_ch2     in   10  encoded TMDS symbol, lane 2
//  o_tmds_ch0     out  10  symbol to serializer lane 0
//  o_tmds_ch1     out  10  symbol to serializer lane 1
//  o_tmds_ch2     out  10  symbol to serializer lane 2
//  o_ser_rst      out  1   active-high reset to all serializers
//  o_link_up      out  1   high only in ACTIVE
//  o_state        out  2   current state encoding (debug)
//  o_relock_count out  8   saturating count of lock losses outside WAIT_LOCK
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-low: i_rst_n=0 at a rising i_clk edge
//    applies reset values at that edge, whatever the lock state. This holds mid-sequence.
//  - Reset values: state=WAIT_LOCK, counter=0, sync flops=0, o_ser_rst=1, o_link_up=0,
//    o_state=0, o_relock_count=0, o_tmds_ch*=CTRL_TOKEN.
//  - i_clk_lock passes through a 2-flop synchronizer to give lock_s (2-cycle latency).
//  - One 16-bit counter is shared by all states. It clears on every state transition.
//  - States are WAIT_LOCK=0, SER_RST=1, IDLE=2, ACTIVE=3:
//    WAIT_LOCK: counter increments while lock_s=1 and clears while lock_s=0.
//      When counter==LOCK_STABLE-1 with lock_s=1, the next state is SER_RST.
//    SER_RST: lasts exactly SER_RST_CYCLES cycles, then IDLE.
//    IDLE: lasts exactly IDLE_CYCLES cycles, then ACTIVE.
//    ACTIVE: stays until lock is lost.
//  - Lock loss: lock_s=0 in SER_RST, IDLE or ACTIVE sends the next state to WAIT_LOCK and
//    increments o_relock_count, which saturates at 255. Lock loss takes priority over any
//    count-done transition in the same cycle.
//  - All outputs are registered and change on the same edge as the state:
//    o_ser_rst=1 in WAIT_LOCK and SER_RST, and 0 otherwise.
//    o_tmds_ch* = CTRL_TOKEN in WAIT_LOCK, SER_RST and IDLE.
//    In ACTIVE, o_tmds_ch* = i_tmds_ch* registered, so there is 1 cycle of latency.
//    o_link_up = (state==ACTIVE). o_state = state.
//  - Worst-case latency from i_clk_lock falling to o_ser_rst=1 is 3 edges
//    (2 synchronizer edges + 1 state edge).
// TESTING (LOCK_STABLE=8, SER_RST_CYCLES=4, IDLE_CYCLES=6)
//  1 Release reset with i_clk_lock=1 -> o_ser_rst=1 for 2+8 cycles, then 4 more in SER_RST.
//    Next, o_ser_rst=0 with o_tmds_ch*=10'b1101010100 for 6 cycles. Then o_link_up=1 and
//    o_tmds_ch0 equals 10'b0110100110 one cycle after it is applied on i_tmds_ch0.
//  2 Pull i_clk_lock low for 1 cycle when the WAIT_LOCK count is 5 -> counter restarts.
//    SER_RST entry is delayed by at least 6 cycles, and o_relock_count stays 0.
//  3 Drop i_clk_lock in ACTIVE -> within 3 cycles o_link_up=0, o_ser_rst=1,
//    o_tmds_ch*=CTRL_TOKEN and o_relock_count=1. Restoring lock repeats the full sequence.
//  4 Drop lock in SER_RST on the same cycle its count completes -> the next state is
//    WAIT_LOCK (not IDLE) and o_relock_count increments.
//  5 Pulse i_rst_n low for 1 cycle during IDLE -> next edge gives o_state=0, o_ser_rst=1
//    and o_relock_count=0. The sequence then restarts while lock stays high.
//  6 Cause 300 lock losses from ACTIVE -> o_relock_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/tmds_link_ctrl.sv
// Start-up / lock-loss sequencer for the three TMDS serializer lanes.
// Qualifies PLL lock, holds serializers in reset, sends control tokens, then passes pixel data.
`timescale 1ns/1ps
module tmds_link_ctrl #(
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned SER_RST_CYCLES = 16,
  parameter int unsigned IDLE_CYCLES    = 64,
  parameter logic [9:0]  CTRL_TOKEN     = 10'b1101010100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clk_lock,
  input  logic [9:0] i_tmds_ch0,
  input  logic [9:0] i_tmds_ch1,
  input  logic [9:0] i_tmds_ch2,
  output logic [9:0] o_tmds_ch0,
  output logic [9:0] o_tmds_ch1,
  output logic [9:0] o_tmds_ch2,
  output logic       o_ser_rst,
  output logic       o_link_up,
  output logic [1:0] o_state,
  output logic [7:0] o_relock_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SER_RST   = 2'd1,
    IDLE      = 2'd2,
    ACTIVE    = 2'd3
  } state_t;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] SER_LAST  = 16'(SER_RST_CYCLES - 1);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        lock_meta, lock_s;
  logic        relock_inc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      state     <= WAIT_LOCK;
      cnt       <= '0;
    end else begin
      lock_meta <= i_clk_lock;
      lock_s    <= lock_meta;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Lock loss is tested before count completion so it wins in the same cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    relock_inc = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_nxt = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = SER_RST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      SER_RST: begin
        if (!lock_s) begin
          state_nxt  = WAIT_LOCK;
          cnt_nxt    = '0;
          relock_inc = 1'b1;
        end else if (cnt == SER_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      IDLE: begin
        if (!lock_s) begin
          state_nxt  = WAIT_LOCK;
          cnt_nxt    = '0;
          relock_inc = 1'b1;
        end else if (cnt == IDLE_LAST) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ACTIVE: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt  = WAIT_LOCK;
          relock_inc = 1'b1;
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_ser_rst      <= 1'b1;
      o_link_up      <= 1'b0;
      o_state        <= 2'd0;
      o_relock_count <= '0;
      o_tmds_ch0     <= CTRL_TOKEN;
      o_tmds_ch1     <= CTRL_TOKEN;
      o_tmds_ch2     <= CTRL_TOKEN;
    end else begin
      o_ser_rst <= (state_nxt == WAIT_LOCK) || (state_nxt == SER_RST);
      o_link_up <= (state_nxt == ACTIVE);
      o_state   <= state_nxt;
      if (relock_inc && (o_relock_count != 8'hFF)) begin
        o_relock_count <= o_relock_count + 8'd1;
      end
      if (state_nxt == ACTIVE) begin
        o_tmds_ch0 <= i_tmds_ch0;
        o_tmds_ch1 <= i_tmds_ch1;
        o_tmds_ch2 <= i_tmds_ch2;
      end else begin
        o_tmds_ch0 <= CTRL_TOKEN;
        o_tmds_ch1 <= CTRL_TOKEN;
        o_tmds_ch2 <= CTRL_TOKEN;
      end
    end
  end

endmodule

// File: tb/tb_tmds_link_ctrl.sv
// Scoreboard bench for tmds_link_ctrl: stimulus pushes per-edge expectations, a negedge
// monitor pops and compares them against the registered outputs.
`timescale 1ns/1ps
module tb_tmds_link_ctrl;

  localparam logic [9:0] CTRL = 10'b1101010100;
  localparam logic [9:0] F0   = 10'b1111100000;
  localparam logic [9:0] D0   = 10'b0110100110;
  localparam logic [9:0] D1   = 10'b1000111001;
  localparam logic [9:0] D2   = 10'b0011001100;
  localparam logic [9:0] E0   = 10'b1010101011;
  localparam logic [9:0] E1   = 10'b0101010110;
  localparam logic [9:0] E2   = 10'b1110001110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic [9:0] in0, in1, in2;
  logic [9:0] out0, out1, out2;
  logic       ser_rst, link_up;
  logic [1:0] st;
  logic [7:0] relock;

  tmds_link_ctrl #(
    .LOCK_STABLE   (8),
    .SER_RST_CYCLES(4),
    .IDLE_CYCLES   (6),
    .CTRL_TOKEN    (CTRL)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_clk_lock    (lock),
    .i_tmds_ch0    (in0),
    .i_tmds_ch1    (in1),
    .i_tmds_ch2    (in2),
    .o_tmds_ch0    (out0),
    .o_tmds_ch1    (out1),
    .o_tmds_ch2    (out2),
    .o_ser_rst     (ser_rst),
    .o_link_up     (link_up),
    .o_state       (st),
    .o_relock_count(relock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          e;
    logic [95:0] nm;
    logic [1:0]  st;
    logic        ser;
    logic        link;
    logic [7:0]  rc;
    logic [9:0]  c0, c1, c2;
  } exp_t;

  exp_t sb[$];
  exp_t it;
  int   compared   = 0;
  int   mismatched = 0;
  bit   done       = 1'b0;

  task automatic push(input int e, input logic [95:0] nm, input logic [1:0] s,
                      input logic [7:0] rc, input logic [9:0] c0, input logic [9:0] c1,
                      input logic [9:0] c2);
    exp_t x;
    x.e    = e;
    x.nm   = nm;
    x.st   = s;
    x.ser  = (s == 2'd0) || (s == 2'd1);
    x.link = (s == 2'd3);
    x.rc   = rc;
    x.c0   = c0;
    x.c1   = c1;
    x.c2   = c2;
    sb.push_back(x);
  endtask

  task automatic goto(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    in0 = a;
    in1 = b;
    in2 = c;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && (sb[0].e <= cyc || done)) begin
      it = sb.pop_front();
      compared++;
      if (it.e != cyc) begin
        mismatched++;
        $display("FAIL %0s: check for edge %0d not reached at edge %0d", it.nm, it.e, cyc);
      end else if ({st, ser_rst, link_up, relock, out0, out1, out2} !==
                   {it.st, it.ser, it.link, it.rc, it.c0, it.c1, it.c2}) begin
        mismatched++;
        $display("FAIL %0s @%0d: got st=%0d ser_rst=%b link_up=%b relock=%0d ch=%b/%b/%b, expected st=%0d ser_rst=%b link_up=%b relock=%0d ch=%b/%b/%b",
                 it.nm, cyc, st, ser_rst, link_up, relock, out0, out1, out2,
                 it.st, it.ser, it.link, it.rc, it.c0, it.c1, it.c2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c, r, s, a;
    int rc_exp;
    rst_n = 1'b0;
    lock  = 1'b1;
    set_in(F0, F0, F0);

    // Power-up sequence with lock already high.
    goto(2);
    b = cyc;
    push(b, "reset", 2'd0, 8'd0, CTRL, CTRL, CTRL);
    rst_n = 1'b1;
    push(b + 9,  "wl_last",   2'd0, 8'd0, CTRL, CTRL, CTRL);
    push(b + 10, "ser_first", 2'd1, 8'd0, CTRL, CTRL, CTRL);
    push(b + 13, "ser_last",  2'd1, 8'd0, CTRL, CTRL, CTRL);
    push(b + 14, "idle_first",2'd2, 8'd0, CTRL, CTRL, CTRL);
    push(b + 19, "idle_last", 2'd2, 8'd0, CTRL, CTRL, CTRL);
    goto(b + 19);
    set_in(CTRL, CTRL, CTRL);
    push(b + 20, "act_first", 2'd3, 8'd0, CTRL, CTRL, CTRL);
    goto(b + 20);
    set_in(D0, D1, D2);
    push(b + 21, "data_d",    2'd3, 8'd0, D0, D1, D2);
    goto(b + 21);
    set_in(E0, E1, E2);
    push(b + 22, "data_e",    2'd3, 8'd0, E0, E1, E2);

    // Lock loss in ACTIVE, then full re-sequence.
    goto(b + 22);
    c = cyc;
    lock = 1'b0;
    push(c + 2, "drop_hold",  2'd3, 8'd0, E0, E1, E2);
    push(c + 3, "drop_wl",    2'd0, 8'd1, CTRL, CTRL, CTRL);
    goto(c + 3);
    lock = 1'b1;
    set_in(F0, F0, F0);
    r = cyc;
    push(r + 9,  "re_wl_last", 2'd0, 8'd1, CTRL, CTRL, CTRL);
    push(r + 10, "re_ser",     2'd1, 8'd1, CTRL, CTRL, CTRL);
    push(r + 14, "re_idle",    2'd2, 8'd1, CTRL, CTRL, CTRL);

    // One-cycle reset pulse during IDLE.
    goto(r + 16);
    rst_n = 1'b0;
    push(r + 17, "rst_in_idle", 2'd0, 8'd0, CTRL, CTRL, CTRL);
    goto(r + 17);
    rst_n = 1'b1;
    b = cyc;

    // One-cycle lock glitch while the WAIT_LOCK count is 5.
    goto(b + 7);
    lock = 1'b0;
    goto(b + 8);
    lock = 1'b1;
    push(b + 10, "glitch_wl",    2'd0, 8'd0, CTRL, CTRL, CTRL);
    push(b + 17, "glitch_wl_end",2'd0, 8'd0, CTRL, CTRL, CTRL);
    push(b + 18, "glitch_ser",   2'd1, 8'd0, CTRL, CTRL, CTRL);

    // Lock loss landing on the SER_RST completion edge.
    s = b + 18;
    goto(s + 1);
    lock = 1'b0;
    push(s + 3, "ser_hold",     2'd1, 8'd0, CTRL, CTRL, CTRL);
    push(s + 4, "ser_drop_wl",  2'd0, 8'd1, CTRL, CTRL, CTRL);
    goto(s + 4);
    lock = 1'b1;
    r = cyc;
    push(r + 10, "r2_ser",      2'd1, 8'd1, CTRL, CTRL, CTRL);
    push(r + 14, "r2_idle",     2'd2, 8'd1, CTRL, CTRL, CTRL);
    push(r + 19, "r2_idle_last",2'd2, 8'd1, CTRL, CTRL, CTRL);
    goto(r + 19);
    set_in(CTRL, CTRL, CTRL);
    push(r + 20, "r2_act",      2'd3, 8'd1, CTRL, CTRL, CTRL);
    goto(r + 20);

    // 300 lock losses from ACTIVE: counter saturates at 255.
    rc_exp = 1;
    for (int i = 0; i < 300; i++) begin
      a = cyc;
      lock = 1'b0;
      rc_exp = (rc_exp == 255) ? 255 : rc_exp + 1;
      push(a + 3, "sat_wl", 2'd0, 8'(rc_exp), CTRL, CTRL, CTRL);
      goto(a + 3);
      lock = 1'b1;
      push(a + 23, "sat_act", 2'd3, 8'(rc_exp), CTRL, CTRL, CTRL);
      goto(a + 23);
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
